// File: rtl/ti_adc_pkg.sv
// rtl/ti_adc_pkg.sv - shared types and arithmetic helpers for the interleaved ADC capture path
package ti_adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Offset-binary code of width 'bits' to a signed two's-complement value.
  // Flipping the MSB is the same as subtracting midscale.
  function automatic int ob2tc(input int code, input int bits);
    int v;
    v = (code ^ (1 << (bits - 1))) & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) begin
      v = v - (1 << bits);
    end
    return v;
  endfunction

  // Signed code minus signed offset, clamped to the signed range of 'bits'.
  function automatic int sat_sub(input int code, input int off, input int bits);
    int d;
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    d  = code - off;
    if (d > hi) begin
      d = hi;
    end else if (d < lo) begin
      d = lo;
    end
    return d;
  endfunction

  // Way that feeds output lane j when way 'rot' holds the oldest sample.
  function automatic int lane_way(input int j, input int rot, input int ways);
    return (j + rot) % ways;
  endfunction

endpackage

// File: rtl/ti_adc_capture_fifo.sv
// rtl/ti_adc_capture_fifo.sv - first-word-fall-through FIFO for core-clock streams
module ti_adc_capture_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ti_adc_capture.sv
// rtl/ti_adc_capture.sv - time-interleaved ADC capture: convert, offset-correct, reorder, buffer
module ti_adc_capture
  import ti_adc_pkg::*;
#(
  parameter int ADC_WAYS   = 8,
  parameter int ADC_BITS   = 9,
  parameter int ROT        = 3,
  parameter int DISCARD    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         core_clk,
  input  logic                         rst,
  input  logic [0:ADC_BITS-1]          adc_data [0:ADC_WAYS-1],
  input  logic                         en,
  input  logic                         off_wr_en,
  input  logic [$clog2(ADC_WAYS)-1:0]  off_wr_way,
  input  logic [ADC_BITS-1:0]          off_wr_val,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [ADC_WAYS*ADC_BITS-1:0] out_data,
  input  logic                         ovf_clr,
  output logic                         ovf,
  output logic [1:0]                   state
);

  localparam int WW = ADC_WAYS * ADC_BITS;
  localparam int CW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

  state_t              cur_state;
  state_t              nxt_state;
  logic [CW-1:0]       flush_cnt;
  logic [CW-1:0]       flush_cnt_nxt;

  logic [ADC_BITS-1:0] s1_data [ADC_WAYS];
  logic                s1_valid;
  logic [ADC_BITS-1:0] off_reg [ADC_WAYS];
  logic [WW-1:0]       s2_next;
  logic [WW-1:0]       s2_data;
  logic                s2_valid;

  logic                fifo_push;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_drop;

  assign state = cur_state;

  // FSM state and flush counter registers.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      flush_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state: flush DISCARD cycles after enable, then run; en low always returns to idle.
  always_comb begin
    nxt_state     = cur_state;
    flush_cnt_nxt = flush_cnt;
    case (cur_state)
      IDLE: begin
        if (en) begin
          flush_cnt_nxt = '0;
          nxt_state     = (DISCARD == 0) ? RUN : FLUSH;
        end
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt + 1'b1;
        if (int'(flush_cnt) == DISCARD - 1) begin
          nxt_state = RUN;
        end
      end
      RUN: begin
        nxt_state = RUN;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
    if (!en) begin
      nxt_state = IDLE;
    end
  end

  // Per-way offset registers written from the control side.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < ADC_WAYS; w++) begin
        off_reg[w] <= '0;
      end
    end else if (off_wr_en) begin
      off_reg[off_wr_way] <= off_wr_val;
    end
  end

  // Stage 1: capture the raw sub-ADC bus every cycle; MSB-first order maps onto [N-1:0].
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < ADC_WAYS; w++) begin
        s1_data[w] <= '0;
      end
    end else begin
      for (int w = 0; w < ADC_WAYS; w++) begin
        s1_data[w] <= adc_data[w];
      end
    end
  end

  // Stage 2 datapath: convert, subtract offset, saturate, and place each way in its time lane.
  for (genvar j = 0; j < ADC_WAYS; j++) begin : g_lane
    localparam int WAY = lane_way(j, ROT, ADC_WAYS);
    assign s2_next[j*ADC_BITS +: ADC_BITS] =
      ADC_BITS'(sat_sub(ob2tc(32'(s1_data[WAY]), ADC_BITS),
                        32'($signed(off_reg[WAY])), ADC_BITS));
  end

  // Stage 2 register for the corrected, time-ordered word.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      s2_data <= '0;
    end else begin
      s2_data <= s2_next;
    end
  end

  // Valid bits: only RUN cycles produce words; dropping en kills everything in flight.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= en && (cur_state == RUN);
      s2_valid <= en && s1_valid;
    end
  end

  assign fifo_push = s2_valid && en;

  ti_adc_capture_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (core_clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (s2_data),
    .pop   (out_ready),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign out_valid = !fifo_empty;

  // Sticky overflow flag; a drop in the same cycle beats a clear.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (fifo_drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ti_adc_capture.sv
// tb/tb_ti_adc_capture.sv - self-checking bench for ti_adc_capture
module tb_ti_adc_capture;

  localparam int WAYS  = 8;
  localparam int BITS  = 9;
  localparam int DISC  = 4;
  localparam int DEPTH = 4;
  localparam int W     = WAYS * BITS;

  logic            core_clk = 1'b0;
  logic            rst;
  logic [0:BITS-1] adc_data [0:WAYS-1];
  logic            en;
  logic            off_wr_en;
  logic [2:0]      off_wr_way;
  logic [BITS-1:0] off_wr_val;
  logic            out_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            ovf_clr;
  logic            ovf;
  logic [1:0]      state;

  int checks   = 0;
  int failures = 0;

  always #5 core_clk = ~core_clk;

  ti_adc_capture #(
    .ADC_WAYS   (WAYS),
    .ADC_BITS   (BITS),
    .ROT        (3),
    .DISCARD    (DISC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .core_clk   (core_clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .en         (en),
    .off_wr_en  (off_wr_en),
    .off_wr_way (off_wr_way),
    .off_wr_val (off_wr_val),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .ovf_clr    (ovf_clr),
    .ovf        (ovf),
    .state      (state)
  );

  typedef struct {
    logic [W-1:0] word;
    int           due;
  } pend_t;

  pend_t        pend[$];
  logic [W-1:0] fq[$];
  int           m_off [WAYS];
  int           run_len;
  int           now;
  bit           m_ovf;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_state(input int n);
    if (n == 0) return 0;
    if (n <= DISC) return 1;
    return 2;
  endfunction

  function automatic logic [W-1:0] ref_word();
    logic [W-1:0] wd;
    int way;
    int v;
    wd = '0;
    for (int j = 0; j < WAYS; j++) begin
      way = (j + 3) % WAYS;
      v = int'(adc_data[way]) - 256 - m_off[way];
      if (v > 255) v = 255;
      if (v < -256) v = -256;
      wd[j*BITS +: BITS] = BITS'(v);
    end
    return wd;
  endfunction

  function automatic logic [BITS-1:0] lane(input int j);
    return out_data[j*BITS +: BITS];
  endfunction

  task automatic model_reset();
    pend.delete();
    fq.delete();
    for (int w = 0; w < WAYS; w++) m_off[w] = 0;
    run_len = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit           was_run;
    bit           want_push;
    bit           full;
    bit           pop_ok;
    bit           dropped;
    logic [W-1:0] pw;
    now++;
    was_run   = (exp_state(run_len) == 2);
    want_push = 1'b0;
    pw        = '0;
    if (off_wr_en) m_off[off_wr_way] = int'($signed(off_wr_val));
    if (!en) begin
      pend.delete();
      run_len = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == now) begin
        pw = pend[0].word;
        want_push = 1'b1;
        pend.delete(0);
      end
      if (was_run) pend.push_back('{word: ref_word(), due: now + 2});
      if (run_len < 1000) run_len++;
    end
    full    = (fq.size() == DEPTH);
    pop_ok  = (fq.size() > 0) && out_ready;
    dropped = want_push && full && !pop_ok;
    if (pop_ok) fq.delete(0);
    if (want_push && !dropped) fq.push_back(pw);
    if (dropped) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic step();
    @(posedge core_clk);
    model_edge();
    @(negedge core_clk);
    chk("state", W'(state), W'(exp_state(run_len)));
    chk("out_valid", W'(out_valid), W'(fq.size() > 0));
    chk("out_data", out_data, (fq.size() > 0) ? fq[0] : '0);
    chk("ovf", W'(ovf), W'(m_ovf));
  endtask

  task automatic wr_off(input int way, input int val);
    off_wr_en  = 1'b1;
    off_wr_way = 3'(way);
    off_wr_val = BITS'(val);
    step();
    off_wr_en  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int delivered;
    int thr;
    rst = 1'b1; en = 1'b0; off_wr_en = 1'b0; off_wr_way = '0; off_wr_val = '0;
    out_ready = 1'b0; ovf_clr = 1'b0; now = 0;
    for (int w = 0; w < WAYS; w++) adc_data[w] = 9'h100;
    model_reset();
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ovf", W'(ovf), '0);
    chk("rst_state", W'(state), '0);
    rst = 1'b0;

    // Startup at midscale.
    en = 1'b1; out_ready = 1'b1;
    repeat (4) step();
    chk("startup_flush", W'(state), W'(1));
    step();
    chk("startup_run", W'(state), W'(2));
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("first_valid_lat", W'(n), W'(3));
    chk("midscale_lanes", out_data, '0);

    // Reorder: way w carries w above midscale.
    for (int w = 0; w < WAYS; w++) adc_data[w] = BITS'(256 + w);
    repeat (3) step();
    for (int j = 0; j < WAYS; j++) chk("reorder_lane", W'(lane(j)), W'((j + 3) % 8));

    // Conversion and saturation with programmed offsets.
    en = 1'b0;
    step();
    wr_off(2, 5);
    wr_off(4, -3);
    wr_off(0, 2);
    for (int w = 0; w < WAYS; w++) adc_data[w] = 9'h100;
    adc_data[2] = 9'h000;
    adc_data[4] = 9'h1FF;
    adc_data[0] = 9'h105;
    en = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("conv_latency", W'(n), W'(8));
    chk("conv_lane7_neg_sat", W'(lane(7)), W'(9'h100));
    chk("conv_lane1_pos_sat", W'(lane(1)), W'(9'h0FF));
    chk("conv_lane5", W'(lane(5)), W'(9'h003));
    chk("conv_lane3_zero", W'(lane(3)), '0);

    // Backpressure and overflow.
    out_ready = 1'b0;
    n = 0;
    while (!ovf && n < 10) begin step(); n++; end
    chk("bp_drop_steps", W'(n), W'(4));
    chk("bp_full_valid", W'(out_valid), W'(1));
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", W'(ovf), W'(1));
    ovf_clr = 1'b0;
    en = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("bp_drained", W'(out_valid), '0);
    ovf_clr = 1'b1;
    step();
    chk("ovf_cleared", W'(ovf), '0);
    ovf_clr = 1'b0;

    // en low with two words in flight and one stored.
    en = 1'b1; out_ready = 1'b0;
    n = 0;
    while (state != 2'd2 && n < 10) begin step(); n++; end
    repeat (3) step();
    chk("enlow_one_stored", W'(out_valid), W'(1));
    en = 1'b0;
    step();
    chk("enlow_idle", W'(state), '0);
    out_ready = 1'b1;
    delivered = 0;
    repeat (6) begin
      if (out_valid) delivered++;
      step();
    end
    chk("enlow_delivered", W'(delivered), W'(1));

    // Randomised traffic against the reference model.
    thr = 2;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) thr = $urandom_range(0, 4);
      en         = ($urandom_range(0, 19) != 0);
      out_ready  = ($urandom_range(0, 3) < thr);
      ovf_clr    = ($urandom_range(0, 7) == 0);
      off_wr_en  = ($urandom_range(0, 9) == 0);
      off_wr_way = 3'($urandom_range(0, 7));
      off_wr_val = BITS'($urandom);
      for (int w = 0; w < WAYS; w++) adc_data[w] = BITS'($urandom);
      step();
    end

    // Asynchronous reset mid-RUN with three stored words and ovf set.
    off_wr_en = 1'b0; ovf_clr = 1'b0;
    en = 1'b1; out_ready = 1'b0;
    repeat (15) step();
    chk("pre_rst_ovf", W'(ovf), W'(1));
    en = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    en = 1'b1;
    n = 0;
    while (state != 2'd2 && n < 10) begin step(); n++; end
    chk("pre_rst_run", W'(state), W'(2));
    chk("pre_rst_valid", W'(out_valid), W'(1));
    rst = 1'b1;
    #1;
    chk("arst_valid", W'(out_valid), '0);
    chk("arst_data", out_data, '0);
    chk("arst_ovf", W'(ovf), '0);
    chk("arst_state", W'(state), '0);
    model_reset();
    en = 1'b0;
    @(negedge core_clk);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
